// File: rtl/uart_tx_ctrl.sv
// UART transmit frame controller: start bit, 8 LSB-first data bits from the serializer, optional parity, stop bit(s), idle gap.
// Build with UART_TX_PARITY_EN defined to include the parity bit; otherwise PAR_EN/PAR_TYP are ignored.
module uart_tx_ctrl #(
  parameter int unsigned STOP_BITS = 1,
  parameter int unsigned FRAME_GAP = 0
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] P_DATA,
  input  logic       Data_Valid,
  input  logic       PAR_EN,
  input  logic       PAR_TYP,
  input  logic       ser_data,
  input  logic       ser_done,
  output logic       ser_en,
  output logic       TX_OUT,
  output logic       Busy
);

  localparam int unsigned CNT_W    = 4;
  localparam int unsigned DATA_LEN = 8;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, GAP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, GAP} state_t;
`endif

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ser_en_d, busy_d;
  logic               accept_c;

`ifdef UART_TX_PARITY_EN
  logic [7:0] data_q;
  logic       par_en_q, par_typ_q;
  logic       par_bit_c;

  assign par_bit_c = par_typ_q ? ~^data_q : ^data_q;

  // Frame options are captured only when a word is accepted
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
    end else if (accept_c) begin
      data_q    <= P_DATA;
      par_en_q  <= PAR_EN;
      par_typ_q <= PAR_TYP;
    end
  end
`else
  logic unused_inputs;
  assign unused_inputs = ^{P_DATA, PAR_EN, PAR_TYP};
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ser_en  <= 1'b0;
      Busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ser_en  <= ser_en_d;
      Busy    <= busy_d;
    end
  end

  // Next-state; one shared counter times DATA watchdog, STOP and GAP
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    accept_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (Data_Valid) begin
          accept_c = 1'b1;
          state_d  = START;
        end
      end
      START: begin
        cnt_d   = '0;
        state_d = DATA;
      end
      DATA: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (ser_done) begin
          cnt_d = '0;
`ifdef UART_TX_PARITY_EN
          state_d = par_en_q ? PARITY : STOP;
`else
          state_d = STOP;
`endif
        end else if (cnt_q == CNT_W'(DATA_LEN - 1)) begin
          cnt_d   = '0;
          state_d = STOP;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        cnt_d   = '0;
        state_d = STOP;
      end
`endif
      STOP: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(STOP_BITS - 1)) begin
          cnt_d = '0;
          if (FRAME_GAP > 0) begin
            state_d = GAP;
          end else if (Data_Valid) begin
            accept_c = 1'b1;
            state_d  = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      GAP: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(FRAME_GAP - 1)) begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
    ser_en_d = (state_d == START) || (state_d == DATA);
    busy_d   = (state_d != IDLE);
  end

  // Line mux from registered state; reset forces IDLE and thus a high line
  always_comb begin
    TX_OUT = 1'b1;
    case (state_q)
      START:   TX_OUT = 1'b0;
      DATA:    TX_OUT = ser_data;
`ifdef UART_TX_PARITY_EN
      PARITY:  TX_OUT = par_bit_c;
`endif
      default: TX_OUT = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: two instances (1 stop/no gap, 2 stop/3 gap) each driving a serializer model.
module tb_uart_tx_ctrl;

`ifdef UART_TX_PARITY_EN
  localparam bit HAS_PAR = 1'b1;
`else
  localparam bit HAS_PAR = 1'b0;
`endif

  typedef struct packed {
    logic tx;
    logic busy;
    logic en;
  } exp_t;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] pdata = 8'h00;
  logic       pe = 1'b0;
  logic       pt = 1'b0;
  logic [1:0] dv = 2'b00;
  logic [1:0] withhold = 2'b00;
  logic [1:0] tx, busy, sen;

  exp_t  exp_q[$];
  int    sel = 0;
  int    n_vec = 0;
  int    n_err = 0;
  string tag = "reset";

  always #5 CLK = ~CLK;

  for (genvar i = 0; i < 2; i++) begin : g_u
    logic [7:0] sh;
    logic [3:0] sc;
    logic       sd, sdn;

    uart_tx_ctrl #(
      .STOP_BITS((i == 0) ? 1 : 2),
      .FRAME_GAP((i == 0) ? 0 : 3)
    ) u_dut (
      .CLK        (CLK),
      .RST        (RST),
      .P_DATA     (pdata),
      .Data_Valid (dv[i]),
      .PAR_EN     (pe),
      .PAR_TYP    (pt),
      .ser_data   (sd),
      .ser_done   (sdn),
      .ser_en     (sen[i]),
      .TX_OUT     (tx[i]),
      .Busy       (busy[i])
    );

    // Serializer model: reloads while disabled, shifts LSB-first when enabled
    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        sh  <= '0;
        sc  <= '0;
        sd  <= 1'b0;
        sdn <= 1'b0;
      end else if (!sen[i]) begin
        sh  <= pdata;
        sc  <= '0;
        sdn <= 1'b0;
      end else begin
        sd  <= sh[0];
        sh  <= {1'b0, sh[7:1]};
        sc  <= sc + 4'd1;
        sdn <= !withhold[i] && (sc == 4'd7);
      end
    end
  end

  task automatic push(input logic t, input logic b, input logic e);
    exp_t x;
    x.tx   = t;
    x.busy = b;
    x.en   = e;
    exp_q.push_back(x);
  endtask

  task automatic push_idle(input int n);
    repeat (n) push(1'b1, 1'b0, 1'b0);
  endtask

  function automatic int frame_len(input logic p, input int stop, input int gap, input logic wd);
    return 9 + ((HAS_PAR && p && !wd) ? 1 : 0) + stop + gap;
  endfunction

  task automatic push_frame(input logic [7:0] d, input logic p, input logic t,
                            input int stop, input int gap, input logic wd);
    push(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) push(d[i], 1'b1, 1'b1);
    if (HAS_PAR && p && !wd) push(t ? ~^d : ^d, 1'b1, 1'b0);
    repeat (stop + gap) push(1'b1, 1'b1, 1'b0);
  endtask

  task automatic compare_now();
    exp_t e;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $error("FAIL %s queue: observed empty expected entry", tag);
    end else begin
      e = exp_q.pop_front();
      n_vec++;
      assert (tx[sel] === e.tx) else begin
        n_err++;
        $error("FAIL %s TX_OUT: observed %b expected %b", tag, tx[sel], e.tx);
      end
      n_vec++;
      assert (busy[sel] === e.busy) else begin
        n_err++;
        $error("FAIL %s Busy: observed %b expected %b", tag, busy[sel], e.busy);
      end
      n_vec++;
      assert (sen[sel] === e.en) else begin
        n_err++;
        $error("FAIL %s ser_en: observed %b expected %b", tag, sen[sel], e.en);
      end
    end
  endtask

  task automatic check(input int n);
    repeat (n) begin
      @(negedge CLK);
      compare_now();
    end
  endtask

  task automatic check_all();
    while (exp_q.size() > 0) check(1);
  endtask

  initial begin
    // Reset state on both instances
    sel = 0; push_idle(1); check(1);
    sel = 1; push_idle(1); check(1);
    RST = 1'b0;
    sel = 0; tag = "idle"; push_idle(2); check(2);

    tag = "a5_even";
    pdata = 8'hA5; pe = 1'b1; pt = 1'b0;
    push_frame(8'hA5, 1'b1, 1'b0, 1, 0, 1'b0); push_idle(1);
    dv[0] = 1'b1; check(1); dv[0] = 1'b0; check_all();

    tag = "01_odd";
    pdata = 8'h01; pt = 1'b1;
    push_frame(8'h01, 1'b1, 1'b1, 1, 0, 1'b0); push_idle(1);
    dv[0] = 1'b1; check(1); dv[0] = 1'b0; check_all();

    tag = "03_odd";
    pdata = 8'h03;
    push_frame(8'h03, 1'b1, 1'b1, 1, 0, 1'b0); push_idle(1);
    dv[0] = 1'b1; check(1); dv[0] = 1'b0; check_all();

    tag = "b2b_nogap";
    pdata = 8'h3C; pt = 1'b0;
    push_frame(8'h3C, 1'b1, 1'b0, 1, 0, 1'b0);
    push_frame(8'hC3, 1'b1, 1'b0, 1, 0, 1'b0); push_idle(1);
    dv[0] = 1'b1; check(1); pdata = 8'hC3;
    check(frame_len(1'b1, 1, 0, 1'b0) - 1);
    check(1); dv[0] = 1'b0; check_all();

    tag = "opts_frozen";
    pdata = 8'h01; pe = 1'b1; pt = 1'b0;
    push_frame(8'h01, 1'b1, 1'b0, 1, 0, 1'b0); push_idle(2);
    dv[0] = 1'b1; check(1); dv[0] = 1'b0; pt = 1'b1; pe = 1'b0;
    check(3); dv[0] = 1'b1; check(1); dv[0] = 1'b0; check_all();
    pe = 1'b1; pt = 1'b0;

    tag = "reset_mid";
    pdata = 8'h96;
    push_frame(8'h96, 1'b1, 1'b0, 1, 0, 1'b0);
    dv[0] = 1'b1; check(1); dv[0] = 1'b0; check(4);
    @(posedge CLK); #2;
    RST = 1'b1; #1;
    exp_q.delete(); push_idle(1); compare_now();
    @(negedge CLK); RST = 1'b0;
    push_idle(2); check(2);

    tag = "after_reset";
    pdata = 8'h5A; pt = 1'b1;
    push_frame(8'h5A, 1'b1, 1'b1, 1, 0, 1'b0); push_idle(1);
    dv[0] = 1'b1; check(1); dv[0] = 1'b0; check_all();

    tag = "watchdog";
    withhold[0] = 1'b1; pdata = 8'hA5; pt = 1'b0;
    push_frame(8'hA5, 1'b1, 1'b0, 1, 0, 1'b1); push_idle(2);
    dv[0] = 1'b1; check(1); dv[0] = 1'b0; check_all();
    withhold[0] = 1'b0;

    sel = 1;
    tag = "ff_stop2_gap3";
    pdata = 8'hFF; pe = 1'b0;
    push_idle(1); check(1);
    push_frame(8'hFF, 1'b0, 1'b0, 2, 3, 1'b0); push_idle(1);
    dv[1] = 1'b1; check(1); dv[1] = 1'b0; check_all();

    tag = "b2b_gap3";
    pdata = 8'h12;
    push_frame(8'h12, 1'b0, 1'b0, 2, 3, 1'b0); push_idle(1);
    push_frame(8'h34, 1'b0, 1'b0, 2, 3, 1'b0); push_idle(2);
    dv[1] = 1'b1; check(1); pdata = 8'h34;
    check(frame_len(1'b0, 2, 3, 1'b0) - 1 + 1);
    check(1); dv[1] = 1'b0; check_all();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
